// File: rtl/frame_rx.sv
// frame_rx: UART receiver for payload+CRC-8 frames with framing-error and inter-byte timeout detection
module frame_rx #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned TIMEOUT_BITS = 20,
   parameter logic [7:0]  CRC_POLY     = 8'h07
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       rx,
   output logic [7:0] data_rx,
   output logic       done_rx,
   output logic       result_checksum,
   output logic       frame_error,
   output logic       busy_rx
);
   localparam int unsigned TMO = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned BW  = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned TW  = $clog2(TMO + 1);
   localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMO_M1  = TW'(TMO - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_q;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d, pay_q, pay_d, crc_q, crc_d, data_q, data_d;
   logic          idx_q, idx_d, chk_q, chk_d, done_q, done_d, ferr_q, ferr_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tick, start, stop_ok, stop_bad, tmo_hit;

   function automatic logic [7:0] crc8(input logic [7:0] b);
      logic [7:0] c;
      c = b;
      for (int i = 0; i < 8; i++) c = {c[6:0], 1'b0} ^ (c[7] ? CRC_POLY : 8'h00);
      return c;
   endfunction

   // two-stage synchroniser on the serial line, idling high out of reset
   always_ff @(posedge clock or negedge reset)
      if (!reset) {rx_meta_q, rx_q} <= 2'b11;
      else        {rx_meta_q, rx_q} <= {rx, rx_meta_q};

   // bit FSM state register
   always_ff @(posedge clock or negedge reset)
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;

   // sample strobe and byte-level events decoded from the current state
   always_comb begin
      tick     = baud_q == (state_q == START ? HALF_M1 : FULL_M1);
      start    = enable && state_q == IDLE && !rx_q;
      stop_ok  = enable && state_q == STOP && tick && rx_q;
      stop_bad = enable && state_q == STOP && tick && !rx_q;
      tmo_hit  = enable && idx_q && state_q == IDLE && rx_q && tmo_q == TMO_M1;
   end

   // bit FSM next state; a low enable forces IDLE from anywhere
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!rx_q) state_d = START;
         START:   if (tick) state_d = rx_q ? IDLE : DATA;
         DATA:    if (tick && bit_q == 3'd7) state_d = STOP;
         STOP:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (!enable) state_d = IDLE;
   end

   // datapath and output next values
   always_comb begin
      baud_d  = (!enable || state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
      bit_d   = (!enable || state_q != DATA) ? '0 : bit_q + {2'b00, tick};
      shift_d = (state_q == DATA && tick) ? {rx_q, shift_q[7:1]} : shift_q;
      pay_d   = (stop_ok && !idx_q) ? shift_q : pay_q;
      crc_d   = (stop_ok && !idx_q) ? crc8(shift_q) : crc_q;
      idx_d   = (!enable || stop_bad || tmo_hit) ? 1'b0 : idx_q ^ stop_ok;
      tmo_d   = (!enable || !idx_q || state_q != IDLE || start || tmo_hit) ? '0 : tmo_q + 1'b1;
      done_d  = stop_ok && idx_q;
      ferr_d  = stop_bad || tmo_hit;
      data_d  = done_d ? pay_q : data_q;
      chk_d   = done_d ? (shift_q == crc_q) : chk_q;
   end

   // datapath and output registers
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         pay_q   <= '0;
         crc_q   <= '0;
         idx_q   <= 1'b0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         chk_q   <= 1'b0;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         pay_q   <= pay_d;
         crc_q   <= crc_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
         chk_q   <= chk_d;
      end

   assign data_rx         = data_q;
   assign done_rx         = done_q;
   assign result_checksum = chk_q;
   assign frame_error     = ferr_q;
   assign busy_rx         = state_q != IDLE || idx_q;
endmodule

// File: tb/tb_frame_rx.sv
// tb_frame_rx: randomized frame_rx bench against an event-level receiver model
module tb_frame_rx;
   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int TB   = 20;
   localparam int TMO  = TB * CPB;
   localparam int CPB1 = 101;

   logic       clk = 0, rst_n = 0, en = 0, rx = 1, rx1 = 1;
   logic [7:0] data_rx, data_rx1;
   logic       done_rx, chk, ferr, busy, done1, chk1, ferr1, busy1;

   always #5 clk = ~clk;

   frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TB), .CRC_POLY(8'h07)) u0 (
      .clock(clk), .reset(rst_n), .enable(en), .rx(rx), .data_rx(data_rx), .done_rx(done_rx),
      .result_checksum(chk), .frame_error(ferr), .busy_rx(busy));

   frame_rx #(.CLKS_PER_BIT(CPB1), .TIMEOUT_BITS(TB), .CRC_POLY(8'h07)) u1 (
      .clock(clk), .reset(rst_n), .enable(en), .rx(rx1), .data_rx(data_rx1), .done_rx(done1),
      .result_checksum(chk1), .frame_error(ferr1), .busy_rx(busy1));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int c; int k; logic [7:0] d; logic ck;} ev_t;
   ev_t        q[$];
   int         vectors = 0, miscompares = 0;
   int         tmo_at = 0;
   logic       idx_m = 0;
   logic [7:0] pay_m = 0, crc_m = 0;
   logic       busy_m = 0, chk_m = 0;
   logic [7:0] data_m = 0;
   int         done_cnt = 0, ferr_cnt = 0, last_ferr_at = 0;
   int         done1_cnt = 0, ferr1_cnt = 0, done1_at = 0;
   bit         chk_on = 0;

   function automatic logic [7:0] crc_ref(input logic [7:0] b);
      logic [15:0] r;
      r = {b, 8'h00};
      for (int i = 15; i >= 8; i--) if (r[i]) r = r ^ (16'h0107 << (i - 8));
      return r[7:0];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // start edge seen by the receiver 3 edges after the line falls
   task automatic start_model(output int d, output logic isp);
      d = cyc + 3;
      if (tmo_at != 0 && tmo_at < d) idx_m = 0;
      else tmo_at = 0;
      isp = !idx_m;
      if (isp) q.push_back(ev_t'{d, 0, 8'h00, 1'b0});
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good_stop, input int cut, input bit use_reset);
      int d, s;
      logic isp, v;
      start_model(d, isp);
      s = d + HALF + 9 * CPB;
      if (cut < 0) begin
         if (!good_stop) begin
            q.push_back(ev_t'{s, 2, 8'h00, 1'b0});
            idx_m = 0;
         end else if (isp) begin
            pay_m = b;
            crc_m = crc_ref(b);
            idx_m = 1;
         end else begin
            q.push_back(ev_t'{s, 1, pay_m, b == crc_m});
            idx_m = 0;
         end
      end
      for (int i = 0; i < 10; i++) begin
         v = (i == 0) ? 1'b0 : (i == 9) ? good_stop : b[i-1];
         rx = v;
         if (i == cut) begin
            idle(CPB / 2);
            q.delete();
            tmo_at = 0;
            idx_m = 0;
            if (use_reset) begin
               rst_n = 0;
               q.push_back(ev_t'{cyc, 4, 8'h00, 1'b0});
               #1;
               check("async_rst_data", data_rx, 0);
               check("async_rst_done", done_rx, 0);
               check("async_rst_chk", chk, 0);
               check("async_rst_ferr", ferr, 0);
               check("async_rst_busy", busy, 0);
            end else begin
               en = 0;
               q.push_back(ev_t'{cyc + 1, 3, 8'h00, 1'b0});
            end
            rx = 1;
            idle(4);
            rst_n = 1;
            en = 1;
            idle(4);
            return;
         end
         if (i == 9 && !good_stop) begin
            idle(HALF + 1);
            rx = 1;
            idle(CPB - HALF - 1);
         end else idle(CPB);
      end
      if (cut < 0 && good_stop && isp) tmo_at = s + TMO;
   endtask

   task automatic glitch();
      int d;
      logic isp;
      start_model(d, isp);
      if (isp) q.push_back(ev_t'{d + HALF, 3, 8'h00, 1'b0});
      rx = 0;
      idle(CPB / 4);
      rx = 1;
      idle(CPB);
      if (!isp) tmo_at = d + HALF + TMO;
   endtask

   task automatic send1(input logic [7:0] b);
      logic v;
      for (int i = 0; i < 10; i++) begin
         v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
         rx1 = v;
         idle(CPB1);
      end
   endtask

   initial begin
      int c0, f0, n0, n1, g;
      logic [7:0] pb, cb;
      fork
         forever begin : cmp
            ev_t e;
            logic ed, ef;
            @(negedge clk);
            if (chk_on) begin
               ed = 0;
               ef = 0;
               while (q.size() > 0 && q[0].c <= cyc) begin
                  e = q.pop_front();
                  case (e.k)
                     0: busy_m = 1;
                     1: begin ed = e.c == cyc; data_m = e.d; chk_m = e.ck; busy_m = 0; end
                     2: begin ef = e.c == cyc; busy_m = 0; end
                     3: busy_m = 0;
                     default: begin busy_m = 0; data_m = 0; chk_m = 0; end
                  endcase
               end
               if (tmo_at != 0 && tmo_at == cyc) begin
                  ef = 1;
                  busy_m = 0;
               end
               check("done_rx", done_rx, ed);
               check("frame_error", ferr, ef);
               check("busy_rx", busy, busy_m);
               check("data_rx", data_rx, data_m);
               check("result_checksum", chk, chk_m);
               if (done_rx) done_cnt++;
               if (ferr) begin ferr_cnt++; last_ferr_at = cyc; end
            end
         end
         forever begin
            @(negedge clk);
            if (done1) begin done1_cnt++; done1_at = cyc; end
            if (ferr1) ferr1_cnt++;
         end
      join_none

      idle(3);
      check("reset_data", data_rx, 0);
      check("reset_done", done_rx, 0);
      check("reset_chk", chk, 0);
      check("reset_ferr", ferr, 0);
      check("reset_busy", busy, 0);
      rst_n = 1;
      en = 1;
      idle(3);
      chk_on = 1;

      check("crc_ref_AA", crc_ref(8'hAA), 8'h5F);
      check("crc_ref_00", crc_ref(8'h00), 8'h00);
      check("crc_ref_01", crc_ref(8'h01), 8'h07);
      check("crc_ref_FF", crc_ref(8'hFF), 8'hF3);

      c0 = done_cnt; f0 = ferr_cnt;
      send_byte(8'hAA, 1, -1, 0);
      send_byte(8'h5F, 1, -1, 0);
      idle(5);
      check("c1_data", data_rx, 8'hAA);
      check("c1_chk", chk, 1);
      check("c1_done_count", done_cnt - c0, 1);
      check("c1_ferr_count", ferr_cnt - f0, 0);

      send_byte(8'hAA, 1, -1, 0);
      send_byte(8'h00, 1, -1, 0);
      idle(5);
      check("c2_data", data_rx, 8'hAA);
      check("c2_chk", chk, 0);

      c0 = done_cnt; f0 = ferr_cnt;
      send_byte(8'h3C, 0, -1, 0);
      idle(5);
      check("c3_ferr_count", ferr_cnt - f0, 1);
      check("c3_done_count", done_cnt - c0, 0);
      send_byte(8'h00, 1, -1, 0);
      send_byte(8'h00, 1, -1, 0);
      idle(5);
      check("c3_data", data_rx, 8'h00);
      check("c3_chk", chk, 1);

      f0 = ferr_cnt;
      n0 = cyc;
      send_byte(8'h55, 1, -1, 0);
      idle(TMO + 40);
      check("c4_ferr_count", ferr_cnt - f0, 1);
      check("c4_ferr_cycle", last_ferr_at, n0 + 3 + HALF + 9 * CPB + TMO);
      check("c4_data_held", data_rx, 8'h00);
      send_byte(8'h01, 1, -1, 0);
      send_byte(8'h07, 1, -1, 0);
      idle(5);
      check("c4_data", data_rx, 8'h01);
      check("c4_chk", chk, 1);

      c0 = done_cnt; f0 = ferr_cnt;
      glitch();
      idle(5);
      check("c5_glitch_busy", busy, 0);
      send_byte(8'h12, 1, -1, 0);
      send_byte(crc_ref(8'h12), 1, 3, 0);
      idle(5);
      check("c5_abort_data", data_rx, 8'h01);
      check("c5_abort_busy", busy, 0);
      check("c5_done_count", done_cnt - c0, 0);
      check("c5_ferr_count", ferr_cnt - f0, 0);

      send_byte(8'hFF, 1, 4, 1);
      send_byte(8'hFF, 1, -1, 0);
      send_byte(8'hF3, 1, -1, 0);
      idle(5);
      check("c6_data", data_rx, 8'hFF);
      check("c6_chk", chk, 1);

      f0 = ferr_cnt;
      send_byte(8'h5A, 1, -1, 0);
      idle(TMO - (CPB - HALF));
      send_byte(crc_ref(8'h5A), 1, -1, 0);
      idle(5);
      check("edge_no_timeout", ferr_cnt - f0, 0);
      check("edge_data", data_rx, 8'h5A);
      send_byte(8'hC3, 1, -1, 0);
      idle(TMO - (CPB - HALF) + 1);
      send_byte(8'h77, 1, -1, 0);
      send_byte(crc_ref(8'h77), 1, -1, 0);
      idle(5);
      check("edge_timeout", ferr_cnt - f0, 1);
      check("edge_data2", data_rx, 8'h77);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 9) == 0) glitch();
         pb = 8'($urandom);
         send_byte(pb, $urandom_range(0, 9) != 0, -1, 0);
         g = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 40) : $urandom_range(0, 30);
         idle(g);
         cb = $urandom_range(0, 1) ? crc_ref(pb) : 8'($urandom);
         send_byte(cb, $urandom_range(0, 19) != 0, -1, 0);
         idle($urandom_range(0, 10));
      end
      idle(TMO + 40);

      send1(8'hAA);
      n1 = cyc;
      send1(8'h5F);
      idle(50);
      check("slow_done_count", done1_cnt, 1);
      check("slow_done_cycle", done1_at, n1 + 3 + CPB1 / 2 + 9 * CPB1);
      check("slow_data", data_rx1, 8'hAA);
      check("slow_chk", chk1, 1);
      check("slow_ferr_count", ferr1_cnt, 0);
      check("slow_busy", busy1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
